// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, redirect flushes,
// data-memory wait holds with timeout detection, and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_rd,
    input  logic             redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              lu;
    logic              mem_stall;
    logic              hold_mode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign lu = ex_memRead && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    assign mem_stall = mem_req && !mem_ready;

    // A held EX/MEM keeps redirect and lu stable, so they are only decoded once the wait ends.
    assign hold_mode = (state == TIMEOUT) || ((state == MEM_WAIT) && !mem_ready);

    always_comb begin
        pc_write      = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        pipe_hold     = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            ifid_write_en = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_bubble  = 1'b1;
        end else if (hold_mode || mem_stall) begin
            pipe_hold     = 1'b1;
            pc_write      = 1'b0;
            ifid_write_en = 1'b0;
        end else if (redirect) begin
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_bubble  = 1'b1;
        end else if (lu) begin
            pc_write      = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = TIMEOUT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            TIMEOUT: state_nxt = TIMEOUT;
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (!pc_write)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // TIMEOUT is left only through reset, so the state itself is the sticky flag.
    assign mem_timeout = (state == TIMEOUT);
    assign stall_count = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs2, ex_memRead, redirect, mem_req, mem_ready;
    logic             pc_write, ifid_write_en, ifid_flush, idex_bubble, exmem_bubble, pipe_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    int m_held  = 0;
    bit m_to    = 1'b0;
    int m_stall = 0;
    bit model_valid = 1'b0;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd), .redirect(redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .pipe_hold(pipe_hold),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_write_en, ifid_flush, idex_bubble, exmem_bubble, pipe_hold}
    function automatic logic [5:0] exp_out();
        bit load_use;
        load_use = ex_memRead && ex_rd != 0 &&
                   (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
        if (!rst_n)                          return 6'b001110;
        if (m_to)                            return 6'b000001;
        if (m_held > 0 && !mem_ready)        return 6'b000001;
        if (m_held == 0 && mem_req && !mem_ready) return 6'b000001;
        if (redirect)                        return 6'b111110;
        if (load_use)                        return 6'b000100;
        return 6'b110000;
    endfunction

    always @(posedge clk) begin
        logic [5:0] e;
        e = exp_out();
        if (!rst_n) begin
            m_held      <= 0;
            m_to        <= 1'b0;
            m_stall     <= 0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (!e[5] && m_stall < MAXC) m_stall <= m_stall + 1;
            if (m_to) begin
            end else if (m_held > 0) begin
                if (mem_ready)                m_held <= 0;
                else if (m_held + 1 == MAX_WAIT) m_to <= 1'b1;
                else                          m_held <= m_held + 1;
            end else if (mem_req && !mem_ready) begin
                m_held <= 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e, a;
        if (model_valid) begin
            e = exp_out();
            a = {pc_write, ifid_write_en, ifid_flush, idex_bubble, exmem_bubble, pipe_hold};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL ctrl_outputs t=%0t got=%b want=%b", $time, a, e);
            end
            total++;
            if (mem_timeout !== m_to) begin
                bad++;
                $display("FAIL mem_timeout t=%0t got=%b want=%b", $time, mem_timeout, m_to);
            end
            total++;
            if ({28'b0, stall_count} !== m_stall) begin
                bad++;
                $display("FAIL stall_count t=%0t got=%0d want=%0d", $time, stall_count, m_stall);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    task automatic step(input bit rn, input int rs1, input int rs2, input bit u2,
                        input bit mrd, input int rd, input bit rdr, input bit mq, input bit mrdy);
        rst_n = rn; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs2 = u2;
        ex_memRead = mrd; ex_rd = 5'(rd); redirect = rdr; mem_req = mq; mem_ready = mrdy;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_exmem_bubble", exmem_bubble, 1);
        chk("rst_pipe_hold", pipe_hold, 0);
        tick(); tick();
        idle();
        chk("post_rst_stall", stall_count, 0);
        chk("post_rst_timeout", mem_timeout, 0);
        chk("post_rst_pc_write", pc_write, 1);
        tick();

        // load-use on rs1: exactly one bubble
        step(1, 5, 7, 1, 1, 5, 0, 0, 0);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_we", ifid_write_en, 0);
        chk("lu_idex_bubble", idex_bubble, 1);
        tick();
        idle();
        chk("lu_release", pc_write, 1);
        chk("lu_stall_count", stall_count, 1);
        tick();

        // no hazard: rd=x0, rs2 match without rs2 use
        step(1, 0, 3, 1, 1, 0, 0, 0, 0);
        chk("x0_pc_write", pc_write, 1);
        tick();
        step(1, 1, 5, 0, 1, 5, 0, 0, 0);
        chk("rs2_unused_pc_write", pc_write, 1);
        chk("rs2_unused_bubble", idex_bubble, 0);
        tick();

        // redirect overrides load-use
        step(1, 5, 0, 0, 1, 5, 1, 0, 0);
        chk("redir_flush", ifid_flush, 1);
        chk("redir_exmem", exmem_bubble, 1);
        chk("redir_pc_write", pc_write, 1);
        tick();
        idle();
        chk("redir_no_stall", stall_count, 1);
        tick();

        // memory wait of 3 cycles
        step(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        idle();
        chk("w_rst_stall", stall_count, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 2, 0, 0, 0, 0, 1, 0);
            chk("wait_hold", pipe_hold, 1);
            chk("wait_pc_write", pc_write, 0);
            tick();
        end
        step(1, 1, 2, 0, 0, 0, 0, 1, 1);
        chk("wait_release_hold", pipe_hold, 0);
        chk("wait_release_pc", pc_write, 1);
        tick();
        idle();
        chk("wait_stall_count", stall_count, 3);
        chk("wait_back_to_run", pipe_hold, 0);
        tick();

        // timeout after MAX_WAIT hold cycles, sticky, cleared by reset
        for (int i = 0; i < MAX_WAIT; i++) begin
            step(1, 1, 2, 0, 0, 0, 0, 1, 0);
            chk("to_hold", pipe_hold, 1);
            chk("to_not_yet", mem_timeout, 0);
            tick();
        end
        step(1, 1, 2, 0, 0, 0, 0, 1, 0);
        chk("to_flag", mem_timeout, 1);
        tick();
        step(1, 1, 2, 0, 0, 0, 0, 1, 1);
        chk("to_late_ready_hold", pipe_hold, 1);
        chk("to_sticky", mem_timeout, 1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        idle();
        chk("to_rst_flag", mem_timeout, 0);
        chk("to_rst_stall", stall_count, 0);
        chk("to_rst_pc", pc_write, 1);
        tick();

        // saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(1, 6, 0, 0, 1, 6, 0, 0, 0);
            tick();
        end
        idle();
        chk("sat_stall_count", stall_count, MAXC);
        tick();

        // randomized traffic
        step(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RISC-V pipeline.
- Drives PC write, IF/ID write-enable and flush, ID/EX and EX/MEM bubble insertion, and a global hold for the downstream pipeline registers.
- Resolves load-use hazards, control redirects (jump, jump_return, taken branch resolved in MEM), and multi-cycle data-memory waits.
- Sits beside the pipeline registers; replaces the standalone IF flush OR-gate.

Parameters:
MAX_WAIT, 16, memory-wait cycles allowed before declaring timeout (2..65535)
CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  pipeline clock; state updates on posedge
rst_n  input  1  synchronous active-low reset
id_rs1  input  5  rs1 of instruction in ID
id_rs2  input  5  rs2 of instruction in ID
id_uses_rs2  input  1  ID instruction reads rs2 (R/S/B type)
ex_memRead  input  1  instruction in EX is a load
ex_rd  input  5  destination of instruction in EX
redirect  input  1  jump | jump_return | taken branch, from MEM stage
mem_req  input  1  MEM stage performs load/store this cycle
mem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC may advance
ifid_write_en  output  1  IF/ID capture enable
ifid_flush  output  1  IF/ID loads NOP (0x00000013)
idex_bubble  output  1  ID/EX control fields forced to 0
exmem_bubble  output  1  EX/MEM control fields forced to 0
pipe_hold  output  1  ID/EX, EX/MEM, MEM/WB keep current contents
mem_timeout  output  1  sticky: memory wait exceeded MAX_WAIT
stall_count  output  CNT_W  cycles with pc_write=0 since reset, saturating

Behaviour:
- State register, posedge clk: RUN, MEM_WAIT, TIMEOUT.
- wait_cnt, clog2(MAX_WAIT)+1 bits.
- Outputs are combinational from state and inputs, so they are stable before the IF/ID negedge capture.
- Reset (rst_n=0 at posedge): state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0.
- While rst_n=0: pc_write=0, ifid_write_en=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, pipe_hold=0.
- Reset mid-wait or in TIMEOUT returns to RUN next cycle.
- Load-use hazard: lu = ex_memRead && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
- Defaults in RUN: pc_write=1, ifid_write_en=1, all flush/bubble/hold=0.
- RUN priority, highest first:
  1. mem_req && !mem_ready: pipe_hold=1, pc_write=0, ifid_write_en=0; next state MEM_WAIT, wait_cnt=1.
  2. redirect: ifid_flush=1, idex_bubble=1, exmem_bubble=1, pc_write=1 (PC takes redirect target). A redirect suppresses lu.
  3. lu: pc_write=0, ifid_write_en=0, idex_bubble=1; stay RUN. The load advances, so lu clears next cycle (exactly 1 bubble).
- mem_req && mem_ready in RUN: no stall.
- MEM_WAIT:
  - Outputs: pipe_hold=1, pc_write=0, ifid_write_en=0, no flush/bubble. redirect and lu are ignored, since the held EX_MEM keeps them stable.
  - mem_ready=1: outputs revert to RUN decode this same cycle (redirect/lu evaluated); next state RUN, wait_cnt=0.
  - Else if wait_cnt==MAX_WAIT-1: next state TIMEOUT.
  - Else wait_cnt+1.
- TIMEOUT:
  - Hold outputs as MEM_WAIT; mem_timeout=1 from the first TIMEOUT cycle.
  - Late mem_ready is ignored.
  - Exit only via reset.
- stall_count: +1 on each posedge where rst_n=1 and pc_write=0; saturates at all-ones, no wrap.
- No state other than the reset state is reachable without a mem_req.
- An illegal state encoding decodes to RUN on the next cycle.

Test Plan:
1. Load-use: `lw x5` in EX (ex_memRead=1, ex_rd=5), ID reads rs1=5 -> exactly 1 cycle pc_write=0, ifid_write_en=0, idex_bubble=1; stall_count=1.
2. rd=x0 or rs2 match with id_uses_rs2=0 -> no stall; outputs remain at RUN defaults.
3. Redirect with simultaneous lu -> same cycle ifid_flush=1, idex_bubble=1, exmem_bubble=1, pc_write=1; no stall.
4. mem_req=1, mem_ready low 3 cycles, then high -> pipe_hold=1 for 3 cycles, released in the mem_ready cycle; stall_count=3; state RUN after.
5. mem_ready never asserted, MAX_WAIT=4 -> TIMEOUT after 4 hold cycles, mem_timeout=1 and sticky. A later mem_ready keeps hold. rst_n=0 for 1 cycle -> RUN, mem_timeout=0, stall_count=0.
6. Saturation: CNT_W=4, force 20 stall cycles -> stall_count stops at 15.
